pong_sfx_sequencer: RTL and testbench
=====================================

# pong_sfx_sequencer

Parametrised sound-effect sequencer that sits between the game logic and the audio codec output path. It turns one-cycle-or-level game events (paddle hit, wall bounce, point scored, game over, …) into a timed sequence of tone codes on `toneSelect`. Events are prioritised, coalesced and optionally preemptive, with a silent gap between consecutive tones. It replaces the undriven tone-select register in the top level and scales to any event count.

## Interface
Parameters:
- `NUM_EVENTS`, 4: number of event channels; channel index = priority (highest index wins).
- `TONE_WIDTH`, 3: width of `toneSelect`; must satisfy 2^TONE_WIDTH ≥ NUM_EVENTS+1.
- `DURATION`, 5_000_000: tone length in clock cycles (100 ms at 50 MHz); must be ≥1.
- `GAP`, 500_000: silence between consecutive tones in cycles; 0 allowed.
- `PREEMPT`, 0: 1 = a higher-priority pending event aborts the current tone.

Ports:
- `clock` in 1: system clock, 50 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `enable` in 1: game running; low flushes and silences.
- `mute` in 1: forces `toneSelect` to 0; sequencing continues.
- `event_in` in NUM_EVENTS: event requests; rising edge = one request.
- `toneSelect` out TONE_WIDTH: 0 = silence, i+1 = tone for event i.
- `toneActive` out 1: high while in PLAY, regardless of `mute`.
- `busy` out 1: high in PLAY or GAP, or when any pending bit is set.
- `dropCount` out 8: saturating count of coalesced or preempted requests.

## Operation
- Edge detect: register `event_in` to `event_q`; request[i] = `event_in[i]` & ~`event_q[i]`.
- Pending bitmap `pend[NUM_EVENTS-1:0]`: a request sets its bit. A request whose bit is already set is coalesced, and `dropCount` increments by 1.
- Arbiter: `sel` = highest set index of `pend`.
- FSM states and transitions:
  - IDLE → PLAY when `pend` ≠ 0. Load `cur`=`sel`, clear `pend[sel]`, counter = DURATION-1.
  - PLAY: counter decrements each cycle. At 0, go to GAP (counter = GAP-1) if GAP>0; otherwise behave as the GAP exit immediately.
  - GAP: counter decrements. At 0, go to PLAY with the next `sel` if `pend` ≠ 0, else go to IDLE.
  - PREEMPT=1 only: in PLAY, if `sel` > `cur`, restart PLAY with `sel` in the next cycle. Clear its pend bit, reload DURATION-1, and increment `dropCount` (the aborted tone is not resumed). No preemption in GAP; GAP always completes.
- A request for channel `cur` during PLAY sets `pend[cur]`, so the tone replays after the gap.
- A request arriving on the same cycle its pend bit is cleared by a load is kept: the bit stays set.
- Multiple simultaneous requests: all bits set, then served in descending index order.
- `enable` low is synchronous. Clear `pend`, go to IDLE, counter = 0, output silence. `event_q` keeps tracking the input, so a level held across the enable rise is not a request. `dropCount` is not cleared.
- `toneSelect` = (state==PLAY && !mute) ? `cur`+1 : 0, registered.
- Counter width = clog2(max(DURATION,GAP,2)). `dropCount` saturates at 255.

## Timing
- Reset values: state IDLE, `pend`=0, `event_q`=0, `toneSelect`=0, `toneActive`=0, `busy`=0, `dropCount`=0.
- Latency: input rising edge sampled at edge k → `pend` set after k → PLAY and `toneSelect` valid after edge k+1, i.e. 2 cycles.
- Tone occupies exactly DURATION cycles and the gap exactly GAP cycles. Back-to-back period = DURATION+GAP.
- A preempting request sampled at edge k, with `pend` set after k, changes `toneSelect` after edge k+1.
- All outputs are registered; no combinational input→output path.
- `rst_n` assertion mid-tone silences the output immediately (asynchronous).

## Test plan
Common setup: DURATION=8, GAP=2, NUM_EVENTS=4, `enable`=1.
- **Single event:** pulse `event_in[1]` at edge 10 → `toneSelect`=2 for edges 11–18 (8 cycles), then 0. `busy` falls after the gap ends, at edge 21.
- **Simultaneous events:** `event_in`=4'b1011 in one cycle → tones 4, 2, 1, each 8 cycles, separated by 2-cycle gaps. `dropCount`=0.
- **Coalescing:** two `event_in[0]` pulses while channel 0 is pending (during another tone) → it plays once and `dropCount`=1. Hold `event_in[2]` high for 50 cycles → a single tone.
- **Preemption:** with PREEMPT=1, play channel 0, then pulse channel 3 at cycle 3 of the tone → `toneSelect` switches to 4 two cycles later for a full 8 cycles, and `dropCount`=1. With PREEMPT=0 the same stimulus plays 1, then the gap, then 4.
- **Mute and enable:** `mute` during a tone → `toneSelect`=0 while `toneActive`=1 and timing is unchanged. `enable` low mid-tone with 2 pending → next cycle IDLE, `pend`=0, output silent.
- **Asynchronous reset:** assert `rst_n` low between clock edges mid-tone → outputs are 0 before the next edge. On release, no tone plays even though `event_in` is held high.

Source files
------------

// File: rtl/pong_sfx_sequencer.sv
// Prioritised, coalescing sound-effect sequencer: turns game events into timed tone codes.
`timescale 1ns/1ps
module pong_sfx_sequencer #(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned TONE_WIDTH = 3,
    parameter int unsigned DURATION   = 5_000_000,
    parameter int unsigned GAP        = 500_000,
    parameter int unsigned PREEMPT    = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  mute,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic [TONE_WIDTH-1:0] toneSelect,
    output logic                  toneActive,
    output logic                  busy,
    output logic [7:0]            dropCount
);
    localparam int unsigned CNT_MAX = (DURATION > GAP) ? ((DURATION > 2) ? DURATION : 2)
                                                       : ((GAP > 2) ? GAP : 2);
    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam int unsigned IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int unsigned ADD_W = $clog2(NUM_EVENTS + 2);
    localparam logic [CNT_W-1:0] DUR_LOAD = CNT_W'(DURATION - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [IDX_W-1:0]      cur, cur_d;
    logic [NUM_EVENTS-1:0] pend, pend_d;
    logic [NUM_EVENTS-1:0] event_q;
    logic                  armed;
    logic [TONE_WIDTH-1:0] tone_d;
    logic                  active_d;
    logic                  busy_d;
    logic [7:0]            drop_d;

    logic [NUM_EVENTS-1:0] req;
    logic [NUM_EVENTS-1:0] clr;
    logic [NUM_EVENTS-1:0] coalesce;
    logic [IDX_W-1:0]      sel;
    logic [ADD_W-1:0]      drop_add;
    logic [31:0]           drop_sum;
    logic                  load;
    logic                  preempt;

    // State, bookkeeping and registered outputs; armed suppresses a spurious edge right after reset
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur        <= '0;
            pend       <= '0;
            event_q    <= '0;
            armed      <= 1'b0;
            toneSelect <= '0;
            toneActive <= 1'b0;
            busy       <= 1'b0;
            dropCount  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cur        <= cur_d;
            pend       <= pend_d;
            event_q    <= event_in;
            armed      <= 1'b1;
            toneSelect <= tone_d;
            toneActive <= active_d;
            busy       <= busy_d;
            dropCount  <= drop_d;
        end
    end

    // Edge detect, arbitration, sequencing and next output values
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cur_d    = cur;
        clr      = '0;
        load     = 1'b0;
        preempt  = 1'b0;
        drop_add = '0;
        sel      = '0;
        req      = armed ? (event_in & ~event_q) : '0;

        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            if (pend[i]) sel = IDX_W'(i);
        end

        case (state)
            S_IDLE: begin
                if (pend != '0) load = 1'b1;
            end
            S_PLAY: begin
                if (cnt == '0) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (pend != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if ((PREEMPT != 0) && (pend != '0) && (sel > cur)) begin
                    load    = 1'b1;
                    preempt = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    if (pend != '0) load = 1'b1;
                    else            state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d  = S_PLAY;
            cur_d    = sel;
            cnt_d    = DUR_LOAD;
            clr[sel] = 1'b1;
        end

        // A request on a bit cleared by this cycle's load is a fresh request, not a coalesce
        coalesce = req & pend & ~clr;
        pend_d   = (pend & ~clr) | req;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            drop_add = drop_add + ADD_W'(coalesce[i]);
        end
        drop_add = drop_add + ADD_W'(preempt);

        if (!enable) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            pend_d   = '0;
            drop_add = '0;
        end

        drop_sum = 32'(dropCount) + 32'(drop_add);
        drop_d   = (drop_sum > 32'd255) ? 8'd255 : drop_sum[7:0];
        tone_d   = ((state_d == S_PLAY) && !mute) ? (TONE_WIDTH'(cur_d) + TONE_WIDTH'(1)) : '0;
        active_d = (state_d == S_PLAY);
        busy_d   = (state_d != S_IDLE) || (pend_d != '0);
    end
endmodule

// File: tb/tb_pong_sfx_sequencer.sv
// Scoreboard bench for pong_sfx_sequencer: non-preemptive and preemptive instances side by side.
`timescale 1ns/1ps
module tb_pong_sfx_sequencer;
    localparam int NE  = 4;
    localparam int TW  = 3;
    localparam int DUR = 8;
    localparam int GP  = 2;

    typedef struct packed {
        logic [TW-1:0] tone;
        logic          active;
        logic          busy;
        logic [7:0]    drop;
    } obs_t;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          mute = 1'b0;
    logic [NE-1:0] event_in = '0;
    logic [TW-1:0] tone0, tone1;
    logic          act0, act1, busy0, busy1;
    logic [7:0]    drop0, drop1;

    int tests_run = 0;
    int failures  = 0;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    // Reference model: absolute-time phase ends, pending set, priority by scan
    int            t = 0;
    logic [NE-1:0] m_prev = '0;
    bit            m_armed = 1'b0;
    logic [NE-1:0] m_pend[2];
    bit            m_play[2];
    bit            m_gap[2];
    int            m_cur[2];
    int            m_play_end[2];
    int            m_gap_end[2];
    int            m_drop[2];

    // Observation history gathered by the stimulus process
    int hist0[8];
    int hist1[8];
    int busyc0, actc0;
    int seq0[$];
    int seq1[$];
    int last0, last1;

    pong_sfx_sequencer #(.NUM_EVENTS(NE), .TONE_WIDTH(TW), .DURATION(DUR), .GAP(GP), .PREEMPT(0)) u_np (
        .clock(clock), .rst_n(rst_n), .enable(enable), .mute(mute), .event_in(event_in),
        .toneSelect(tone0), .toneActive(act0), .busy(busy0), .dropCount(drop0)
    );

    pong_sfx_sequencer #(.NUM_EVENTS(NE), .TONE_WIDTH(TW), .DURATION(DUR), .GAP(GP), .PREEMPT(1)) u_pe (
        .clock(clock), .rst_n(rst_n), .enable(enable), .mute(mute), .event_in(event_in),
        .toneSelect(tone1), .toneActive(act1), .busy(busy1), .dropCount(drop1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int highest(input logic [NE-1:0] p);
        int h = -1;
        for (int i = 0; i < NE; i++) if (p[i]) h = i;
        return h;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_armed = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_play[m] = 0; m_gap[m] = 0; m_cur[m] = 0;
            m_play_end[m] = 0; m_gap_end[m] = 0; m_drop[m] = 0;
        end
    endtask

    // Predict both instances after the coming clock edge and queue the expectations
    task automatic model_step(input logic en, input logic mu, input logic [NE-1:0] ev);
        logic [NE-1:0] req;
        obs_t e;
        t++;
        req     = m_armed ? (ev & ~m_prev) : '0;
        m_prev  = ev;
        m_armed = 1'b1;
        for (int m = 0; m < 2; m++) begin
            int start;
            bit want;
            bit pre;
            start = -1; want = 0; pre = 0;
            if (!en) begin
                m_pend[m] = '0; m_play[m] = 0; m_gap[m] = 0;
            end else begin
                if (m_play[m]) begin
                    if (t > m_play_end[m]) begin
                        if (GP > 0) begin
                            m_play[m] = 0; m_gap[m] = 1; m_gap_end[m] = t + GP - 1;
                        end else want = 1;
                    end else if (m == 1 && highest(m_pend[m]) > m_cur[m]) begin
                        start = highest(m_pend[m]);
                        pre = 1;
                    end
                end else if (m_gap[m]) begin
                    if (t > m_gap_end[m]) begin
                        m_gap[m] = 0; want = 1;
                    end
                end else want = 1;
                if (want) begin
                    start = highest(m_pend[m]);
                    if (start < 0) m_play[m] = 0;
                end
                for (int i = 0; i < NE; i++)
                    if (req[i] && m_pend[m][i] && i != start) m_drop[m]++;
                if (pre) m_drop[m]++;
                if (m_drop[m] > 255) m_drop[m] = 255;
                if (start >= 0) begin
                    m_pend[m][start] = 1'b0;
                    m_play[m] = 1; m_cur[m] = start; m_play_end[m] = t + DUR - 1;
                end
                m_pend[m] = m_pend[m] | req;
            end
            e.tone   = (m_play[m] && !mu) ? TW'(m_cur[m] + 1) : '0;
            e.active = m_play[m];
            e.busy   = m_play[m] || m_gap[m] || (m_pend[m] != '0);
            e.drop   = 8'(m_drop[m]);
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endtask

    // Monitor: pop one expectation per instance after every clock edge and compare
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                a = {tone0, act0, busy0, drop0};
                tests_run++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb_nopre t=%0d: got tone=%0d act=%0b busy=%0b drop=%0d expected tone=%0d act=%0b busy=%0b drop=%0d",
                             t, a.tone, a.active, a.busy, a.drop, e.tone, e.active, e.busy, e.drop);
                end
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                a = {tone1, act1, busy1, drop1};
                tests_run++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb_pre t=%0d: got tone=%0d act=%0b busy=%0b drop=%0d expected tone=%0d act=%0b busy=%0b drop=%0d",
                             t, a.tone, a.active, a.busy, a.drop, e.tone, e.active, e.busy, e.drop);
                end
            end
        end
    end

    task automatic clear_obs();
        for (int i = 0; i < 8; i++) begin hist0[i] = 0; hist1[i] = 0; end
        busyc0 = 0; actc0 = 0; last0 = 0; last1 = 0;
        seq0.delete(); seq1.delete();
    endtask

    // Drive one cycle from a negedge, predict it, then record what the DUTs show
    task automatic cyc(input logic en, input logic mu, input logic [NE-1:0] ev);
        enable = en; mute = mu; event_in = ev;
        model_step(en, mu, ev);
        @(negedge clock);
        hist0[tone0]++;
        hist1[tone1]++;
        if (busy0) busyc0++;
        if (act0)  actc0++;
        if (tone0 != 0 && int'(tone0) != last0) seq0.push_back(int'(tone0));
        if (tone1 != 0 && int'(tone1) != last1) seq1.push_back(int'(tone1));
        last0 = int'(tone0);
        last1 = int'(tone1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, '0);
    endtask

    initial begin
        int d0, d1;
        logic en_r, mu_r;
        logic [NE-1:0] ev_r;

        model_reset();
        clear_obs();
        repeat (3) @(negedge clock);
        chk("reset_tone", int'(tone0), 0);
        chk("reset_active", int'(act0), 0);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_drop", int'(drop0), 0);
        chk("reset_tone_pre", int'(tone1), 0);
        rst_n = 1'b1;
        idle(4);

        // Single event: eight cycles of tone 2, busy until the gap ends
        clear_obs();
        cyc(1'b1, 1'b0, 4'b0010);
        idle(24);
        chk("single_tone_len", hist0[2], DUR);
        chk("single_busy_len", busyc0, 1 + DUR + GP);
        chk("single_tone_cnt", seq0.size(), 1);

        // Simultaneous requests served highest index first
        clear_obs();
        d0 = int'(drop0);
        cyc(1'b1, 1'b0, 4'b1011);
        idle(40);
        chk("simul_count", seq0.size(), 3);
        if (seq0.size() >= 3) begin
            chk("simul_first", seq0[0], 4);
            chk("simul_second", seq0[1], 2);
            chk("simul_third", seq0[2], 1);
        end
        chk("simul_drop", int'(drop0) - d0, 0);
        chk("simul_tone4_len", hist0[4], DUR);

        // Two pulses on a pending channel play once and count one drop
        clear_obs();
        d0 = int'(drop0);
        cyc(1'b1, 1'b0, 4'b1000);
        idle(3);
        cyc(1'b1, 1'b0, 4'b0001);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0001);
        idle(40);
        chk("coalesce_drop", int'(drop0) - d0, 1);
        chk("coalesce_tone1_len", hist0[1], DUR);
        chk("coalesce_tone4_len", hist0[4], DUR);

        // A held level is a single request
        clear_obs();
        d0 = int'(drop0);
        repeat (50) cyc(1'b1, 1'b0, 4'b0100);
        idle(20);
        chk("hold_tone3_len", hist0[3], DUR);
        chk("hold_drop", int'(drop0) - d0, 0);

        // Preemption: channel 3 aborts channel 0 in the preemptive instance only
        clear_obs();
        d1 = int'(drop1);
        cyc(1'b1, 1'b0, 4'b0001);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b1000);
        idle(30);
        chk("preempt_tone1_len", hist1[1], 3);
        chk("preempt_tone4_len", hist1[4], DUR);
        chk("preempt_drop", int'(drop1) - d1, 1);
        chk("nopre_tone1_len", hist0[1], DUR);
        chk("nopre_tone4_len", hist0[4], DUR);
        if (seq0.size() >= 2) chk("nopre_order", seq0[1], 4);
        else chk("nopre_order_count", seq0.size(), 2);

        // Mute hides the tone but not its timing
        clear_obs();
        cyc(1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0000);
        repeat (3) begin
            cyc(1'b1, 1'b1, 4'b0000);
            chk("mute_active", int'(act0), 1);
            chk("mute_tone", int'(tone0), 0);
        end
        idle(20);
        chk("mute_tone2_len", hist0[2], DUR - 3);
        chk("mute_active_len", actc0, DUR);

        // Enable low mid-tone flushes pending requests
        clear_obs();
        cyc(1'b1, 1'b0, 4'b0001);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0110);
        cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        chk("disable_busy", int'(busy0), 0);
        chk("disable_tone", int'(tone0), 0);
        chk("disable_busy_pre", int'(busy1), 0);
        idle(15);
        chk("disable_no_tone2", hist0[2], 0);
        chk("disable_no_tone3", hist0[3], 0);

        // Asynchronous reset mid-tone, event level held across release
        cyc(1'b1, 1'b0, 4'b0010);
        repeat (4) cyc(1'b1, 1'b0, 4'b0010);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_tone", int'(tone0), 0);
        chk("areset_active", int'(act0), 0);
        chk("areset_busy", int'(busy0), 0);
        chk("areset_tone_pre", int'(tone1), 0);
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        clear_obs();
        repeat (20) cyc(1'b1, 1'b0, 4'b0010);
        chk("areset_no_tone", hist0[2], 0);
        chk("areset_no_busy", busyc0, 0);
        idle(4);

        // Randomised traffic against the model
        en_r = 1'b1; mu_r = 1'b0; ev_r = '0;
        repeat (3000) begin
            for (int i = 0; i < NE; i++)
                if ($urandom_range(0, 11) == 0) ev_r[i] = ~ev_r[i];
            if ($urandom_range(0, 39) == 0) mu_r = ~mu_r;
            if (en_r) begin
                if ($urandom_range(0, 149) == 0) en_r = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en_r = 1'b1;
            end
            cyc(en_r, mu_r, ev_r);
        end
        idle(30);
        chk("sb_drained", exp_q0.size() + exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
